// File: rtl/roll_pkg.sv
// Shared constants for the roll-mode decimator: mode encodings and default widths.
package roll_pkg;

  localparam int DEF_WIDTH    = 12;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_PRESC_W  = 16;

  localparam logic [1:0] ROLL_SAMPLE = 2'b00;
  localparam logic [1:0] ROLL_MAX    = 2'b01;
  localparam logic [1:0] ROLL_MIN    = 2'b10;

endpackage

// File: rtl/roll_chan_acc.sv
// Per-channel window accumulator: holds the first sample, running max or running min.
module roll_chan_acc
  import roll_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] acc_q, acc_d;

  // Combine the incoming sample with the accumulator; a window start simply loads it.
  always_comb begin
    next  = acc_q;
    acc_d = acc_q;
    if (start) begin
      next = sample;
    end else begin
      case (mode)
        ROLL_MAX: next = (sample > acc_q) ? sample : acc_q;
        ROLL_MIN: next = (sample < acc_q) ? sample : acc_q;
        default:  next = acc_q;  // sample mode (and the reserved code) keep the first sample
      endcase
    end
    if (en) acc_d = next;
  end

  // Accumulator register, advanced only on accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/roll_decimator.sv
// Multi-channel roll-mode decimator with sample / peak-detect windows and a
// valid/ready result register carrying a write strobe and sticky overrun flag.
module roll_decimator
  import roll_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int PRESC_W  = DEF_PRESC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] value,
  input  logic [PRESC_W-1:0]        prescaler,
  input  logic [1:0]                mode,
  output logic [CHANNELS*WIDTH-1:0] val_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      w_clk,
  output logic                      overrun
);

  localparam logic [PRESC_W:0] ONE_EXT = (PRESC_W+1)'(1);

  logic                      start_q, start_d;
  logic [PRESC_W-1:0]        cnt_q, cnt_d;
  logic [PRESC_W-1:0]        p_lat_q, p_lat_d;
  logic [1:0]                m_lat_q, m_lat_d;
  logic [CHANNELS*WIDTH-1:0] val_out_q, val_out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      w_clk_q, w_clk_d;
  logic                      overrun_q, overrun_d;

  logic                      win_start;
  logic [1:0]                eff_mode;
  logic                      last_sample;
  logic                      done;
  logic [CHANNELS*WIDTH-1:0] next_all;
  logic [CHANNELS*WIDTH-1:0] acc_all;

  // Window bookkeeping: a pending clear makes this sample the first of a fresh window.
  always_comb begin
    win_start = start_q | clear;
    eff_mode  = win_start ? mode : m_lat_q;
    // cnt_q is the index of the last accepted sample, so this sample's index is cnt_q+1.
    if (win_start) last_sample = (prescaler == '0);
    else           last_sample = (({1'b0, cnt_q} + ONE_EXT) == {1'b0, p_lat_q});
    done = in_valid & last_sample;
  end

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_chan
      roll_chan_acc #(.WIDTH(WIDTH)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .start  (win_start),
        .en     (in_valid),
        .mode   (eff_mode),
        .sample (value[c*WIDTH +: WIDTH]),
        .acc    (acc_all[c*WIDTH +: WIDTH]),
        .next   (next_all[c*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Next-state for counter, latches, result register, handshake and overrun.
  always_comb begin
    start_d     = start_q;
    cnt_d       = cnt_q;
    p_lat_d     = p_lat_q;
    m_lat_d     = m_lat_q;
    val_out_d   = val_out_q;
    out_valid_d = out_valid_q;
    w_clk_d     = 1'b0;
    overrun_d   = clear ? 1'b0 : overrun_q;

    if (clear) begin
      start_d = 1'b1;
      cnt_d   = '0;
    end

    if (in_valid) begin
      if (win_start) begin
        p_lat_d = prescaler;
        m_lat_d = mode;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
      start_d = 1'b0;
      if (done) begin
        start_d = 1'b1;
        cnt_d   = '0;
      end
    end

    if (done) begin
      val_out_d   = next_all;
      w_clk_d     = 1'b1;
      out_valid_d = 1'b1;
      // Newest result wins; flag it only if the old one was never taken.
      if (out_valid_q && !out_ready) overrun_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q     <= 1'b1;
      cnt_q       <= '0;
      p_lat_q     <= '0;
      m_lat_q     <= ROLL_SAMPLE;
      val_out_q   <= '0;
      out_valid_q <= 1'b0;
      w_clk_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      start_q     <= start_d;
      cnt_q       <= cnt_d;
      p_lat_q     <= p_lat_d;
      m_lat_q     <= m_lat_d;
      val_out_q   <= val_out_d;
      out_valid_q <= out_valid_d;
      w_clk_q     <= w_clk_d;
      overrun_q   <= overrun_d;
    end
  end

  assign val_out   = val_out_q;
  assign out_valid = out_valid_q;
  assign w_clk     = w_clk_q;
  assign overrun   = overrun_q;

  // The per-channel accumulator value is only needed internally through next_all.
  logic unused_acc;
  assign unused_acc = ^acc_all;

endmodule

// File: tb/tb_roll_decimator.sv
// Self-checking bench for roll_decimator: directed scenarios plus a randomized
// run against a window-list reference model.
module tb_roll_decimator;

  localparam int W  = 12;
  localparam int CH = 2;
  localparam int PW = 16;

  logic               clk, rst, clear, in_valid, out_ready;
  logic [CH*W-1:0]    value;
  logic [PW-1:0]      prescaler;
  logic [1:0]         mode;
  logic [CH*W-1:0]    val_out;
  logic               out_valid, w_clk, overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the current window is kept as a list of sample sets.
  logic [CH*W-1:0] win[$];
  int unsigned     m_p;
  logic [1:0]      m_m;
  logic [CH*W-1:0] m_val;
  logic            m_valid, m_wclk, m_over;

  roll_decimator #(.WIDTH(W), .CHANNELS(CH), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .value(value),
    .prescaler(prescaler), .mode(mode), .val_out(val_out), .out_valid(out_valid),
    .out_ready(out_ready), .w_clk(w_clk), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CH*W-1:0] pack2(input int a, input int b);
    logic [W-1:0] la, lb;
    la = W'(a);
    lb = W'(b);
    return {lb, la};
  endfunction

  function automatic logic [CH*W-1:0] window_result();
    logic [CH*W-1:0] r;
    for (int c = 0; c < CH; c++) begin
      int best;
      best = int'(win[0][c*W +: W]);
      for (int i = 1; i < win.size(); i++) begin
        int s;
        s = int'(win[i][c*W +: W]);
        if (m_m == 2'b01 && s > best) best = s;
        if (m_m == 2'b10 && s < best) best = s;
      end
      r[c*W +: W] = W'(best);
    end
    return r;
  endfunction

  task automatic model_reset();
    win.delete();
    m_val = '0; m_valid = 0; m_wclk = 0; m_over = 0; m_p = 0; m_m = 0;
  endtask

  // Apply one cycle of inputs, clock it, then advance the model.
  task automatic step(input logic iv, input logic [CH*W-1:0] v, input int p,
                      input logic [1:0] md, input logic rdy, input logic clr);
    logic prev_valid;
    in_valid = iv; value = v; prescaler = PW'(p); mode = md; out_ready = rdy; clear = clr;
    @(posedge clk);
    #1;
    prev_valid = m_valid;
    m_wclk = 0;
    if (clr) begin
      m_over = 0;
      win.delete();
    end
    if (iv) begin
      if (win.size() == 0) begin
        m_p = p;
        m_m = md;
      end
      win.push_back(v);
      if (win.size() == m_p + 1) begin
        m_val   = window_result();
        m_wclk  = 1;
        if (prev_valid && !rdy) m_over = 1;
        m_valid = 1;
        win.delete();
      end else if (prev_valid && rdy) m_valid = 0;
    end else if (prev_valid && rdy) m_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    #1;
    model_reset();
    n_cmp++;
    if (val_out !== '0 || out_valid !== 1'b0 || w_clk !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset: val_out=%h out_valid=%b w_clk=%b overrun=%b required all 0",
               val_out, out_valid, w_clk, overrun);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_passthrough();
    for (int k = 1; k <= 3; k++) begin
      step(1, pack2(k, 100 + k), 0, 2'b00, 1, 0);
      n_cmp++;
      if (val_out[W-1:0] !== W'(k) || w_clk !== 1'b1 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL passthrough[%0d]: ch0=%0d w_clk=%b valid=%b required ch0=%0d w_clk=1 valid=1",
                 k, val_out[W-1:0], w_clk, out_valid, k);
      end
    end
    idle(1);
  endtask

  task automatic test_decimation();
    for (int i = 0; i < 8; i++) begin
      step(1, pack2(10 * (i + 1), 0), 3, 2'b00, 1, 0);
      n_cmp++;
      if (w_clk !== (i % 4 == 3)) begin
        n_err++;
        $display("FAIL decim_wclk[%0d]: w_clk=%b required %b", i, w_clk, (i % 4 == 3));
      end
      if (i % 4 == 3) begin
        n_cmp++;
        if (val_out[W-1:0] !== W'(i == 3 ? 10 : 50)) begin
          n_err++;
          $display("FAIL decim_val[%0d]: ch0=%0d required %0d", i, val_out[W-1:0], (i == 3 ? 10 : 50));
        end
      end
    end
    idle(1);
  endtask

  task automatic test_peak();
    int s0[4] = '{5, 900, 7, 3};
    int s1[4] = '{'hFFF, 0, 0, 0};
    for (int md = 1; md <= 2; md++) begin
      for (int i = 0; i < 4; i++) step(1, pack2(s0[i], s1[i]), 3, 2'(md), 1, 0);
      n_cmp++;
      if (val_out[W-1:0] !== W'(md == 1 ? 900 : 3) || w_clk !== 1'b1) begin
        n_err++;
        $display("FAIL peak_ch0 mode=%0d: ch0=%0d w_clk=%b required %0d w_clk=1",
                 md, val_out[W-1:0], w_clk, (md == 1 ? 900 : 3));
      end
      n_cmp++;
      if (val_out[2*W-1:W] !== W'(md == 1 ? 'hFFF : 0)) begin
        n_err++;
        $display("FAIL peak_ch1 mode=%0d: ch1=%h required %h", md, val_out[2*W-1:W], (md == 1 ? 'hFFF : 0));
      end
    end
    idle(1);
  endtask

  task automatic test_overrun();
    step(1, pack2(1, 0), 0, 2'b00, 0, 0);
    step(1, pack2(2, 0), 0, 2'b00, 0, 0);
    n_cmp++;
    if (val_out[W-1:0] !== W'(2) || out_valid !== 1'b1 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set: ch0=%0d valid=%b overrun=%b required 2 1 1",
               val_out[W-1:0], out_valid, overrun);
    end
    step(0, '0, 0, 2'b00, 0, 1);
    n_cmp++;
    if (overrun !== 1'b0 || out_valid !== 1'b1 || val_out[W-1:0] !== W'(2)) begin
      n_err++;
      $display("FAIL overrun_clear: overrun=%b valid=%b ch0=%0d required 0 1 2",
               overrun, out_valid, val_out[W-1:0]);
    end
    step(1, pack2(3, 0), 0, 2'b00, 1, 0);
    n_cmp++;
    if (overrun !== 1'b0 || out_valid !== 1'b1 || val_out[W-1:0] !== W'(3) || w_clk !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_consume: overrun=%b valid=%b ch0=%0d w_clk=%b required 0 1 3 1",
               overrun, out_valid, val_out[W-1:0], w_clk);
    end
    idle(1);
    n_cmp++;
    if (out_valid !== 1'b0 || w_clk !== 1'b0) begin
      n_err++;
      $display("FAIL drain: valid=%b w_clk=%b required 0 0", out_valid, w_clk);
    end
  endtask

  task automatic test_mid_window();
    int plist[6] = '{3, 3, 1, 1, 1, 1};
    bit exp_w[6] = '{0, 0, 0, 1, 0, 1};
    for (int i = 0; i < 6; i++) begin
      step(1, pack2(i + 1, 0), plist[i], 2'b00, 1, 0);
      n_cmp++;
      if (w_clk !== exp_w[i]) begin
        n_err++;
        $display("FAIL midpresc_wclk[%0d]: w_clk=%b required %b", i, w_clk, exp_w[i]);
      end
    end
    n_cmp++;
    if (val_out[W-1:0] !== W'(5)) begin
      n_err++;
      $display("FAIL midpresc_val: ch0=%0d required 5", val_out[W-1:0]);
    end
    step(1, pack2(7, 0), 3, 2'b00, 1, 0);
    step(1, pack2(8, 0), 3, 2'b00, 1, 0);
    test_reset();
    step(1, pack2(9, 0), 1, 2'b00, 1, 0);
    step(1, pack2(11, 0), 1, 2'b00, 1, 0);
    n_cmp++;
    if (w_clk !== 1'b1 || val_out[W-1:0] !== W'(9)) begin
      n_err++;
      $display("FAIL reset_newwin: w_clk=%b ch0=%0d required 1 9", w_clk, val_out[W-1:0]);
    end
    idle(1);
  endtask

  task automatic test_random();
    test_reset();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, CH*W'($urandom), $urandom_range(0, 4),
           2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      n_cmp++;
      if (val_out !== m_val || out_valid !== m_valid || w_clk !== m_wclk || overrun !== m_over) begin
        n_err++;
        $display("FAIL random[%0d]: val=%h valid=%b w_clk=%b over=%b required val=%h valid=%b w_clk=%b over=%b",
                 i, val_out, out_valid, w_clk, overrun, m_val, m_valid, m_wclk, m_over);
      end
    end
  endtask

  initial begin
    rst = 0; clear = 0; in_valid = 0; out_ready = 1; value = '0; prescaler = '0; mode = '0;
    test_reset();
    test_passthrough();
    test_decimation();
    test_peak();
    test_overrun();
    test_mid_window();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
